// File: rtl/regfile_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_pkg : shared widths, zero-register index and depth helper.  Rev 1.0
// ----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NRD_DEF      = 2;
  localparam int ZERO_REG_IDX = 0;

  function automatic int rf_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_regfile_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_regfile_if : write, issue and read bundle of the register file.  Rev 1.0
// ----------------------------------------------------------------------------
interface pipe_regfile_if #(
  parameter int DATA_W = regfile_pkg::DATA_W_DEF,
  parameter int ADDR_W = regfile_pkg::ADDR_W_DEF,
  parameter int NRD    = regfile_pkg::NRD_DEF
);

  logic                    reg_wr;
  logic                    overflow;
  logic                    reg_dst;
  logic [ADDR_W-1:0]       rt;
  logic [ADDR_W-1:0]       rd;
  logic [DATA_W-1:0]       busw;
  logic [NRD*ADDR_W-1:0]   raddr;
  logic [NRD*DATA_W-1:0]   rdata;
  logic                    issue_vld;
  logic [ADDR_W-1:0]       issue_dst;
  logic                    stall;

  modport master (
    output reg_wr, overflow, reg_dst, rt, rd, busw, raddr, issue_vld, issue_dst,
    input  rdata, stall
  );

  modport slave (
    input  reg_wr, overflow, reg_dst, rt, rd, busw, raddr, issue_vld, issue_dst,
    output rdata, stall
  );

endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_scoreboard : per-register pending bits and read-port stall compare.
// Rev 1.0
// ----------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = NRD_DEF
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  i_issue_vld,
  input  wire logic [ADDR_W-1:0]     i_issue_dst,
  input  wire logic                  i_clr_vld,
  input  wire logic [ADDR_W-1:0]     i_clr_idx,
  input  wire logic [NRD*ADDR_W-1:0] i_raddr,
  input  wire logic                  i_byp_vld,
  input  wire logic [ADDR_W-1:0]     i_byp_idx,
  output logic                       o_stall
);

  localparam int DEPTH = rf_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] C_ZERO = ADDR_W'(ZERO_REG_IDX);

  logic [DEPTH-1:0]  r_pending;
  logic [DEPTH-1:0]  w_set;
  logic [DEPTH-1:0]  w_clr;
  logic [ADDR_W-1:0] w_idx;
  logic              w_stall;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_issue_vld && (i_issue_dst != C_ZERO)) w_set[i_issue_dst] = 1'b1;
    if (i_clr_vld) w_clr[i_clr_idx] = 1'b1;
  end

  // A new issue to the same register outranks the retiring write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pending <= '0;
    else     r_pending <= (r_pending & ~w_clr) | w_set;
  end

  always_comb begin
    w_stall = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NRD; k++) begin
      w_idx = i_raddr[k*ADDR_W +: ADDR_W];
      if (r_pending[w_idx] && !(i_byp_vld && (w_idx == i_byp_idx))) w_stall = 1'b1;
    end
  end

  assign o_stall = w_stall;

endmodule
`default_nettype wire

// File: rtl/pipe_regfile.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_regfile : multi-port register file with pending scoreboard; define
// REGFILE_BYPASS_EN to forward busw to same-cycle reads.  Rev 1.0
// ----------------------------------------------------------------------------
module pipe_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = NRD_DEF
) (
  input  wire logic     clk,
  input  wire logic     rst,
  pipe_regfile_if.slave bus
);

  localparam int DEPTH = rf_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] C_ZERO = ADDR_W'(ZERO_REG_IDX);

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [ADDR_W-1:0]     w_rw;
  logic                  w_wr_en;
  logic                  w_byp_vld;
  logic [NRD*DATA_W-1:0] w_rdata;
  logic                  w_stall;

  assign w_rw    = bus.reg_dst ? bus.rd : bus.rt;
  assign w_wr_en = bus.reg_wr && !bus.overflow && (w_rw != C_ZERO);

  // Entry 0 is never written, so it reads as zero from reset onward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[w_rw] <= bus.busw;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign w_byp_vld = w_wr_en;
`else
  assign w_byp_vld = 1'b0;
`endif

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_idx;
    assign w_idx = bus.raddr[k*ADDR_W +: ADDR_W];
    assign w_rdata[k*DATA_W +: DATA_W] =
        (w_byp_vld && (w_idx == w_rw)) ? bus.busw : r_mem[w_idx];
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NRD    (NRD)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_issue_vld (bus.issue_vld),
    .i_issue_dst (bus.issue_dst),
    .i_clr_vld   (bus.reg_wr),
    .i_clr_idx   (w_rw),
    .i_raddr     (bus.raddr),
    .i_byp_vld   (w_byp_vld),
    .i_byp_idx   (w_rw),
    .o_stall     (w_stall)
  );

  assign bus.rdata = w_rdata;
  assign bus.stall = w_stall;

endmodule
`default_nettype wire

// File: doc/pipe_regfile.md
PIPE_REGFILE -- requirements
Module: pipe_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width; depth is 2**ADDR_W.
REQ-003 SHALL have parameter NRD, default 2, number of independent read ports.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port reg_wr, input, 1, write request.
REQ-007 SHALL have port overflow, input, 1, arithmetic overflow; suppresses data write.
REQ-008 SHALL have port reg_dst, input, 1, write-index select: 1 selects rd, 0 selects rt.
REQ-009 SHALL have ports rt and rd, input, ADDR_W each, candidate write indices.
REQ-010 SHALL have port busw, input, DATA_W, write data.
REQ-011 SHALL have port raddr, input, NRD*ADDR_W, packed read indices; port k uses slice k.
REQ-012 SHALL have port rdata, output, NRD*DATA_W, packed read data.
REQ-013 SHALL have ports issue_vld (input, 1) and issue_dst (input, ADDR_W), marking a register pending.
REQ-014 SHALL have port stall, output, 1, high when any read port hits a pending register.

Function
REQ-015 SHALL form the write index rw = reg_dst ? rd : rt.
REQ-016 SHALL write busw to entry rw on the rising edge when reg_wr=1, overflow=0 and rw!=0.
REQ-017 SHALL return 0 on any read of index 0 and never write or mark pending index 0.
REQ-018 SHALL drive rdata combinationally from the array, with zero-cycle read latency.
REQ-019 SHALL keep one pending bit per register, set on the edge where issue_vld=1 and issue_dst!=0.
REQ-020 SHALL clear the pending bit of rw on the edge where reg_wr=1, including when overflow=1 and no data is written.
REQ-021 SHALL leave a pending bit set when issue and clear target the same index on the same edge.
REQ-022 SHALL assert stall combinationally when any raddr slice indexes a pending register, except under REQ-025 bypass.
REQ-023 SHALL let every read port observe the same register with identical results.

Reset
REQ-024 SHALL, while rst=1, asynchronously clear all array entries and pending bits to 0, giving rdata=0 and stall=0; a write or issue on the same edge as reset release has no effect.

Configuration
REQ-025 SHALL, with REGFILE_BYPASS_EN defined, forward busw to any read port whose index equals rw when reg_wr=1, overflow=0 and rw!=0, and exclude that index from stall that cycle.
REQ-026 SHALL, with REGFILE_BYPASS_EN undefined, return the pre-edge stored value on same-cycle read/write collisions and compute stall from pending bits only.

Structure
REQ-027 SHALL take DATA_W/ADDR_W defaults and the zero-register index constant from a shared package, regfile_pkg.
REQ-028 SHALL implement the pending-bit vector and stall compare in a single sub-module, regfile_scoreboard.

Verification
REQ-029 SHALL cover: reg_wr=1, reg_dst=1, rd=5, busw=0x1234_5678, then raddr0=5 on the next cycle -> rdata0=0x1234_5678.
REQ-030 SHALL cover: reg_wr=1, overflow=1, rt=7, reg_dst=0, busw=0xFFFF_FFFF -> r7 stays 0 and the pending bit of r7 clears.
REQ-031 SHALL cover: write to index 0 with busw=0xDEAD_BEEF -> rdata=0 on both ports, stall=0.
REQ-032 SHALL cover: issue_vld=1, issue_dst=9, then raddr1=9 -> stall=1; a later write to r9 -> stall=0 on the following cycle.
REQ-033 SHALL cover, with REGFILE_BYPASS_EN: same-cycle write r3=0xA5A5_A5A5 and raddr0=3 -> rdata0=0xA5A5_A5A5 and stall=0; without the macro -> old value is returned.
REQ-034 SHALL cover: assert rst mid-sequence after r4=0x55 is written and r6 is pending -> rdata(r4)=0 and stall=0 with no clock edge.
